// File: rtl/ysyx_23060208_ifu_prefetch_pkg.sv
// Shared definitions for the prefetching instruction fetch unit:
// fetch FSM state encoding, AXI burst/size/response encodings and a
// response-decode helper used by the top level.
package ysyx_23060208_ifu_prefetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_AR    = 2'd1,
        ST_R     = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Any non-OKAY response marks the fetched word as faulting.
    function automatic logic resp_is_fault(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/ysyx_23060208_ifu_queue.sv
// Prefetch queue: circular synchronous FIFO with one extra pointer bit to
// tell full from empty. Flush empties the queue and wins over push/pop.
// Ports:
//   clock, reset        clock, asynchronous active-low reset
//   push_i/push_data_i  write one entry
//   pop_i               remove head (ignored when empty)
//   flush_i             discard all entries
//   empty_o, head_o     head status and contents (read from storage registers)
//   free_slots_o        free entries, computed from the registered pointers
module ysyx_23060208_ifu_queue #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic                     empty_o,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   free_slots_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    used_s;

    assign used_s       = wr_ptr_q - rd_ptr_q;
    assign empty_o      = (used_s == '0);
    assign free_slots_o = PW'(DEPTH) - used_s;
    assign head_o       = mem_q[rd_ptr_q[AW-1:0]];

    // Entry storage; a flushed push is dropped.
    always_ff @(posedge clock) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    // Pointer next-state: flush resets both, otherwise advance independently.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_i && !empty_o) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/ysyx_23060208_ifu_prefetch.sv
// Instruction fetch unit with line prefetch. Issues one aligned INCR burst
// per cache line on the isram AXI read port, keeps the words at or after the
// requested pc and hands {fault, pc, inst} to IDU through the prefetch queue.
// Ports:
//   clock, reset                     clock, asynchronous active-low reset
//   redirect_valid/redirect_pc       EXU redirect pulse and word-aligned target
//   ifu_to_idu_valid/idu_ready/bus   head of the prefetch queue to IDU
//   isram_ar*                        AXI read address channel (master side)
//   isram_r*                         AXI read data channel (master side)
module ysyx_23060208_ifu_prefetch
    import ysyx_23060208_ifu_prefetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    LINE_WORDS = 4,
    parameter int                    FIFO_DEPTH = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h3000_0000,
    parameter logic [3:0]            AXI_ID     = 4'h0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    redirect_valid,
    input  logic [DATA_WIDTH-1:0]   redirect_pc,
    output logic                    ifu_to_idu_valid,
    input  logic                    idu_ready,
    output logic [2*DATA_WIDTH:0]   ifu_to_idu_bus,
    output logic                    isram_arvalid,
    input  logic                    isram_arready,
    output logic [DATA_WIDTH-1:0]   isram_araddr,
    output logic [7:0]              isram_arlen,
    output logic [2:0]              isram_arsize,
    output logic [1:0]              isram_arburst,
    output logic [3:0]              isram_arid,
    input  logic                    isram_rvalid,
    output logic                    isram_rready,
    input  logic [DATA_WIDTH-1:0]   isram_rdata,
    input  logic [1:0]              isram_rresp,
    input  logic                    isram_rlast,
    input  logic [3:0]              isram_rid
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int PW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DATA_WIDTH-1:0] LINE_MASK = DATA_WIDTH'(LINE_WORDS * 4 - 1);
    localparam logic [DATA_WIDTH-1:0] LINE_STEP = DATA_WIDTH'(LINE_WORDS * 4);
    localparam logic [OFF_W-1:0]      BEAT_ONE  = OFF_W'(1'b1);
    localparam logic [PW-1:0]         LINE_SLOTS = PW'(LINE_WORDS);

    fetch_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic [DATA_WIDTH-1:0]   req_pc_q, req_pc_d;     // pc of the outstanding request
    logic [OFF_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic                    redir_pend_q, redir_pend_d; // redirect seen while AR waits
    logic                    stall_q, stall_d;           // fault seen, wait for redirect

    logic                    beat_ok_s, beat_keep_s, beat_fault_s;
    logic [DATA_WIDTH-1:0]   line_base_s;
    logic [2*DATA_WIDTH:0]   push_data_s;
    logic                    q_empty_s;
    logic [PW-1:0]           free_slots_s;

    assign line_base_s  = req_pc_q & ~LINE_MASK;
    // Beats tagged with a foreign id are not ours: no count, no push, no rlast.
    assign beat_ok_s    = isram_rvalid && (isram_rid == AXI_ID);
    assign beat_fault_s = resp_is_fault(isram_rresp);
    // Words before the requested pc within the line are dropped.
    assign beat_keep_s  = (state_q == ST_R) && beat_ok_s && !redirect_valid &&
                          (beat_cnt_q >= req_pc_q[OFF_W+1:2]);
    assign push_data_s  = {beat_fault_s,
                           line_base_s | {{(DATA_WIDTH-OFF_W-2){1'b0}}, beat_cnt_q, 2'b00},
                           isram_rdata};

    assign isram_arvalid    = (state_q == ST_AR);
    assign isram_araddr     = line_base_s;
    assign isram_arlen      = 8'(LINE_WORDS - 1);
    assign isram_arsize     = AXI_SIZE_WORD;
    assign isram_arburst    = AXI_BURST_INCR;
    assign isram_arid       = AXI_ID;
    assign isram_rready     = (state_q == ST_R) || (state_q == ST_DRAIN);
    assign ifu_to_idu_valid = !q_empty_s;

    ysyx_23060208_ifu_queue #(
        .WIDTH (2*DATA_WIDTH+1),
        .DEPTH (FIFO_DEPTH)
    ) u_queue (
        .clock        (clock),
        .reset        (reset),
        .push_i       (beat_keep_s),
        .push_data_i  (push_data_s),
        .pop_i        (ifu_to_idu_valid && idu_ready),
        .flush_i      (redirect_valid),
        .empty_o      (q_empty_s),
        .head_o       (ifu_to_idu_bus),
        .free_slots_o (free_slots_s)
    );

    // Fetch FSM next-state and fetch address bookkeeping.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        req_pc_d     = req_pc_q;
        beat_cnt_d   = beat_cnt_q;
        redir_pend_d = redir_pend_q;
        stall_d      = stall_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            stall_d    = 1'b0;
        end else begin
            fetch_pc_d = fetch_pc_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (!redirect_valid && !stall_q && (free_slots_s >= LINE_SLOTS)) begin
                    state_d  = ST_AR;
                    req_pc_d = fetch_pc_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_AR: begin
                // Address stays put until accepted; a redirect turns the burst into a drain.
                if (isram_arready) begin
                    beat_cnt_d   = '0;
                    redir_pend_d = 1'b0;
                    if (redirect_valid || redir_pend_q) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_R;
                    end
                end else begin
                    redir_pend_d = redir_pend_q | redirect_valid;
                end
            end
            ST_R: begin
                if (redirect_valid) begin
                    state_d = (beat_ok_s && isram_rlast) ? ST_IDLE : ST_DRAIN;
                end else if (beat_keep_s && beat_fault_s) begin
                    stall_d = 1'b1;
                    state_d = isram_rlast ? ST_IDLE : ST_DRAIN;
                end else if (beat_ok_s && isram_rlast) begin
                    state_d    = ST_IDLE;
                    fetch_pc_d = line_base_s + LINE_STEP;
                end else begin
                    state_d = ST_R;
                end
                if (beat_ok_s) begin
                    beat_cnt_d = beat_cnt_q + BEAT_ONE;
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
            end
            ST_DRAIN: begin
                if (beat_ok_s && isram_rlast) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Fetch FSM and address registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            fetch_pc_q   <= RESET_PC;
            req_pc_q     <= RESET_PC;
            beat_cnt_q   <= '0;
            redir_pend_q <= 1'b0;
            stall_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            req_pc_q     <= req_pc_d;
            beat_cnt_q   <= beat_cnt_d;
            redir_pend_q <= redir_pend_d;
            stall_q      <= stall_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060208_ifu_prefetch.sv
module tb_ysyx_23060208_ifu_prefetch;
    localparam logic [31:0] RESET_PC = 32'h3000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ifu_to_idu_valid;
    logic        idu_ready;
    logic [64:0] ifu_to_idu_bus;
    logic        isram_arvalid, isram_arready;
    logic [31:0] isram_araddr;
    logic [7:0]  isram_arlen;
    logic [2:0]  isram_arsize;
    logic [1:0]  isram_arburst;
    logic [3:0]  isram_arid;
    logic        isram_rvalid, isram_rready, isram_rlast;
    logic [31:0] isram_rdata;
    logic [1:0]  isram_rresp;
    logic [3:0]  isram_rid;

    always #5 clock = ~clock;

    ysyx_23060208_ifu_prefetch dut (
        .clock(clock), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ifu_to_idu_valid(ifu_to_idu_valid), .idu_ready(idu_ready),
        .ifu_to_idu_bus(ifu_to_idu_bus),
        .isram_arvalid(isram_arvalid), .isram_arready(isram_arready),
        .isram_araddr(isram_araddr), .isram_arlen(isram_arlen),
        .isram_arsize(isram_arsize), .isram_arburst(isram_arburst),
        .isram_arid(isram_arid),
        .isram_rvalid(isram_rvalid), .isram_rready(isram_rready),
        .isram_rdata(isram_rdata), .isram_rresp(isram_rresp),
        .isram_rlast(isram_rlast), .isram_rid(isram_rid)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instruction memory contents: a fixed function of the address.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Test controls
    bit          fast = 1'b1, hold_ar = 1'b0, fault_en = 1'b0;
    logic [31:0] fault_addr = 32'h0;
    bit          rand_ready = 1'b0, fixed_ready = 1'b1, rnd_ready = 1'b1;
    assign idu_ready = rand_ready ? rnd_ready : fixed_ready;

    // Scoreboard: expected program-order stream {fault, pc, inst}
    logic [64:0] exp_q[$];
    int pop_cnt = 0, fault_pops = 0, ar_cnt = 0;

    // Reference model of the fetch engine, at transaction level
    logic [31:0] ar_expect, ar_saved, ar_start, burst_addr, cur_start;
    bit          ar_seen, ar_drop, burst_active, cur_dropped, stalled;
    int          beat_no;

    task automatic fill(input logic [31:0] target);
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            logic [31:0] pc;
            pc = target + 32'(4 * i);
            exp_q.push_back({fault_en && (pc == fault_addr), pc, memfn(pc)});
        end
    endtask

    // Output monitor: compare each accepted head against the scoreboard
    always @(negedge clock) begin
        if (reset && ifu_to_idu_valid && idu_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got %h expected none", ifu_to_idu_bus);
            end else begin
                check("idu_out", ifu_to_idu_bus, exp_q.pop_front());
            end
            if (ifu_to_idu_bus[64]) fault_pops++;
            pop_cnt++;
        end
    end

    // Random IDU backpressure
    always @(posedge clock) begin
        #1 rnd_ready = ($urandom_range(0, 2) != 0);
    end

    // AXI slave observation + fetch-address model
    always @(negedge clock) begin
        if (!reset) begin
            ar_expect = RESET_PC; ar_seen = 0; ar_drop = 0; burst_active = 0;
            cur_dropped = 0; stalled = 0; beat_no = 0;
        end else begin
            if (isram_arvalid) begin
                if (!ar_seen) begin
                    ar_cnt++;
                    check("ar_addr", isram_araddr, ar_expect & ~32'hF);
                    check("ar_len", isram_arlen, 8'd3);
                    check("ar_size_burst_id", {isram_arsize, isram_arburst, isram_arid},
                          {3'b010, 2'b01, 4'h0});
                    check("ar_while_stalled", stalled, 1'b0);
                    ar_seen = 1; ar_drop = 0; ar_saved = isram_araddr; ar_start = ar_expect;
                end else begin
                    check("ar_stable", {isram_araddr, isram_arlen}, {ar_saved, 8'd3});
                end
                if (isram_arready) begin
                    burst_active = 1; burst_addr = ar_saved; beat_no = 0;
                    cur_dropped = ar_drop; cur_start = ar_start; ar_seen = 0;
                end
            end
            if (isram_rvalid && !isram_rready) check("rready_in_burst", isram_rready, 1'b1);
            if (isram_rvalid && isram_rready && burst_active) begin
                logic [31:0] a;
                a = burst_addr + 32'(4 * beat_no);
                if (!cur_dropped && fault_en && a == fault_addr && a[3:0] >= cur_start[3:0]) begin
                    stalled = 1; cur_dropped = 1;
                end
                if (beat_no == 3) begin
                    burst_active = 0;
                    if (!cur_dropped) ar_expect = burst_addr + 32'd16;
                end
                beat_no++;
            end
            if (redirect_valid) begin
                ar_expect = redirect_pc;
                if (ar_seen) ar_drop = 1;
                cur_dropped = 1; stalled = 0;
            end
        end
    end

    // AXI slave drive
    always @(posedge clock) begin
        #1;
        if (!reset) begin
            isram_arready = 0; isram_rvalid = 0; isram_rdata = 0;
            isram_rresp = 0; isram_rlast = 0; isram_rid = 0;
        end else begin
            isram_arready = hold_ar ? 1'b0 : (fast ? 1'b1 : 1'($urandom_range(0, 1)));
            if (burst_active && (fast || $urandom_range(0, 3) != 0)) begin
                logic [31:0] a;
                a = burst_addr + 32'(4 * beat_no);
                isram_rvalid = 1;
                isram_rdata  = memfn(a);
                isram_rresp  = (fault_en && a == fault_addr) ? 2'b10 : 2'b00;
                isram_rlast  = (beat_no == 3);
                isram_rid    = 4'h0;
            end else begin
                isram_rvalid = 0; isram_rdata = 0; isram_rresp = 0; isram_rlast = 0;
            end
        end
    end

    task automatic do_redirect(input logic [31:0] target);
        @(posedge clock);
        #1 redirect_valid = 1; redirect_pc = target;
        @(posedge clock);
        #1 redirect_valid = 0;
        fill(target);
        @(negedge clock);
        check("flush_head_invalid", ifu_to_idu_valid, 1'b0);
    endtask

    task automatic wait_pops(input int n);
        int start, cyc;
        start = pop_cnt; cyc = 0;
        while (pop_cnt < start + n && cyc < 400) begin
            @(negedge clock);
            cyc++;
        end
        check("pop_progress", (pop_cnt - start) >= n, 1'b1);
    endtask

    initial begin
        int a0, cyc;
        reset = 0; redirect_valid = 0; redirect_pc = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_arvalid", isram_arvalid, 1'b0);
        check("rst_rready", isram_rready, 1'b0);
        check("rst_out_valid", ifu_to_idu_valid, 1'b0);
        fill(RESET_PC);
        @(posedge clock);
        #1 reset = 1;
        // reset fetch from RESET_PC, zero-wait memory
        wait_pops(4);
        // redirect into the middle of a line
        do_redirect(32'h3000_0108);
        wait_pops(4);
        // redirect in the middle of a burst
        fast = 0;
        do_redirect(32'h3000_0200);
        cyc = 0;
        while (!(burst_active && !cur_dropped && burst_addr == 32'h3000_0200 && beat_no == 2)
               && cyc < 300) begin
            @(negedge clock);
            cyc++;
        end
        check("mid_burst_reached", cyc < 300, 1'b1);
        do_redirect(32'h3000_0404);
        wait_pops(4);
        // backpressure: exactly two bursts fit the 8-entry queue
        fast = 1; fixed_ready = 0;
        do_redirect(32'h3000_0800);
        a0 = ar_cnt;
        repeat (40) @(negedge clock);
        check("full_queue_ar_count", 32'(ar_cnt - a0), 32'd2);
        check("full_queue_valid", ifu_to_idu_valid, 1'b1);
        fixed_ready = 1;
        wait_pops(12);
        // fault on beat 2 stalls fetch
        fault_en = 1; fault_addr = 32'h3000_0A08;
        do_redirect(32'h3000_0A00);
        wait_pops(3);
        a0 = ar_cnt;
        repeat (30) @(negedge clock);
        check("fault_stall_ar_count", 32'(ar_cnt - a0), 32'd0);
        check("fault_stall_empty", ifu_to_idu_valid, 1'b0);
        check("fault_delivered", 32'(fault_pops), 32'd1);
        fault_en = 0;
        // arready held low with a redirect while AR waits
        hold_ar = 1;
        do_redirect(32'h3000_0C00);
        cyc = 0;
        while (!isram_arvalid && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        check("ar_raised", isram_arvalid, 1'b1);
        do_redirect(32'h3000_0E04);
        check("ar_held_addr", {isram_arvalid, isram_araddr}, {1'b1, 32'h3000_0C00});
        repeat (3) @(posedge clock);
        #1 hold_ar = 0;
        wait_pops(4);
        // random redirects with random backpressure and memory latency
        fast = 0; rand_ready = 1;
        for (int i = 0; i < 15; i++) begin
            do_redirect(32'h3000_0000 + 32'($urandom_range(0, 1023) * 4));
            repeat ($urandom_range(3, 40)) @(posedge clock);
        end
        rand_ready = 0; fixed_ready = 1;
        do_redirect(32'h3000_1000);
        wait_pops(8);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
